// File: rtl/float_to_int_converter_if.sv
// Handshake bundle for the FP32 -> INT32 converter.
//   master : producer of floats / consumer of integers (drives valid_in,
//            floating_in, ready_in)
//   slave  : the converter (drives ready_out, valid_out, integer_out, flags)
interface float_to_int_converter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid_in;
    logic                  ready_out;
    logic [DATA_WIDTH-1:0] floating_in;
    logic                  valid_out;
    logic                  ready_in;
    logic [DATA_WIDTH-1:0] integer_out;
    logic                  overflow_out;
    logic                  invalid_out;
    logic                  inexact_out;

    modport master (
        output valid_in, floating_in, ready_in,
        input  ready_out, valid_out, integer_out,
        input  overflow_out, invalid_out, inexact_out
    );

    modport slave (
        input  valid_in, floating_in, ready_in,
        output ready_out, valid_out, integer_out,
        output overflow_out, invalid_out, inexact_out
    );
endinterface

// File: rtl/float_to_int_converter.sv
// Multi-cycle IEEE-754 single -> signed 32-bit integer, truncating toward zero.
// The significand is denormalized one bit per cycle until the binary point
// sits below bit 0; bits shifted out on the right accumulate into a sticky bit.
// Ports:
//   clk_in  : clock, rising edge
//   rst_in  : synchronous reset, active-high
//   bus     : slave side of float_to_int_converter_if
//             (valid_in/ready_out/floating_in in, valid_out/ready_in/
//              integer_out/overflow_out/invalid_out/inexact_out out)
module float_to_int_converter #(
    parameter int DATA_WIDTH = 32,
    parameter int MENT_WIDTH = 23,
    parameter int EXPO_WIDTH = 8,
    parameter int EXPO_BIAS  = 127
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    float_to_int_converter_if.slave   bus
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam int EW = EXPO_WIDTH + 2;   // signed unbiased exponent width

    localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [EW-1:0]  E_BIAS  = EW'(EXPO_BIAS);
    localparam logic signed [EW-1:0]  E_MW    = EW'(MENT_WIDTH);
    localparam logic signed [EW-1:0]  E_SAT   = EW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, PREP, SHIFT, DONE} state_t;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  f_q;
    logic [DATA_WIDTH-1:0]  mag_q;
    logic [CW-1:0]          cnt_q;
    logic                   left_q;
    logic                   sticky_q;

    // Field decode of the captured operand
    logic                   sign_q;
    logic [EXPO_WIDTH-1:0]  expo;
    logic [MENT_WIDTH-1:0]  ment;
    logic signed [EW-1:0]   e;
    logic [DATA_WIDTH-1:0]  sig_full;
    logic [CW-1:0]          cnt_n;
    logic [DATA_WIDTH-1:0]  mag_shift;
    logic                   sticky_next;
    logic                   exact_min;

    assign sign_q   = f_q[DATA_WIDTH-1];
    assign expo     = f_q[DATA_WIDTH-2 -: EXPO_WIDTH];
    assign ment     = f_q[MENT_WIDTH-1:0];
    assign e        = $signed({2'b00, expo}) - E_BIAS;
    assign sig_full = DATA_WIDTH'({1'b1, ment});

    // Only meaningful for 0 <= e < DATA_WIDTH-1, where e fits in CW bits
    assign cnt_n = (e < E_MW) ? CW'(MENT_WIDTH) - e[CW-1:0]
                              : e[CW-1:0] - CW'(MENT_WIDTH);

    assign mag_shift   = left_q ? {mag_q[DATA_WIDTH-2:0], 1'b0}
                                : {1'b0, mag_q[DATA_WIDTH-1:1]};
    assign sticky_next = sticky_q | (~left_q & mag_q[0]);

    // -2^31 itself is representable even though e hits the saturation bound
    assign exact_min = sign_q && (e == E_SAT) && (ment == '0);

    function automatic logic [DATA_WIDTH-1:0] apply_sign(
        input logic s, input logic [DATA_WIDTH-1:0] m);
        return s ? (~m + 1'b1) : m;
    endfunction

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state            <= IDLE;
            bus.ready_out    <= 1'b1;
            bus.valid_out    <= 1'b0;
            bus.integer_out  <= '0;
            bus.overflow_out <= 1'b0;
            bus.invalid_out  <= 1'b0;
            bus.inexact_out  <= 1'b0;
            f_q              <= '0;
            mag_q            <= '0;
            cnt_q            <= '0;
            left_q           <= 1'b0;
            sticky_q         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.valid_in) begin
                        f_q           <= bus.floating_in;
                        bus.ready_out <= 1'b0;
                        state         <= PREP;
                    end
                end

                PREP: begin
                    sticky_q <= 1'b0;
                    if (expo == '1) begin
                        // NaN reports invalid only; infinities saturate
                        state            <= DONE;
                        bus.valid_out    <= 1'b1;
                        bus.integer_out  <= (ment != '0 || sign_q) ? MIN_NEG : MAX_POS;
                        bus.overflow_out <= (ment == '0);
                        bus.invalid_out  <= (ment != '0);
                        bus.inexact_out  <= 1'b0;
                    end else if (expo == '0 || e[EW-1]) begin
                        // Zero, denormal or |x| < 1 all truncate to 0
                        state            <= DONE;
                        bus.valid_out    <= 1'b1;
                        bus.integer_out  <= '0;
                        bus.overflow_out <= 1'b0;
                        bus.invalid_out  <= 1'b0;
                        bus.inexact_out  <= (expo != '0) || (ment != '0);
                    end else if (e >= E_SAT) begin
                        state            <= DONE;
                        bus.valid_out    <= 1'b1;
                        bus.integer_out  <= sign_q ? MIN_NEG : MAX_POS;
                        bus.overflow_out <= ~exact_min;
                        bus.invalid_out  <= 1'b0;
                        bus.inexact_out  <= 1'b0;
                    end else if (cnt_n == '0) begin
                        state            <= DONE;
                        bus.valid_out    <= 1'b1;
                        bus.integer_out  <= apply_sign(sign_q, sig_full);
                        bus.overflow_out <= 1'b0;
                        bus.invalid_out  <= 1'b0;
                        bus.inexact_out  <= 1'b0;
                    end else begin
                        mag_q  <= sig_full;
                        cnt_q  <= cnt_n;
                        left_q <= (e >= E_MW);
                        state  <= SHIFT;
                    end
                end

                SHIFT: begin
                    mag_q    <= mag_shift;
                    sticky_q <= sticky_next;
                    cnt_q    <= cnt_q - 1'b1;
                    // Last shift: register the signed result from the
                    // shifted value so DONE is entered with it in place
                    if (cnt_q == CW'(1)) begin
                        state            <= DONE;
                        bus.valid_out    <= 1'b1;
                        bus.integer_out  <= apply_sign(sign_q, mag_shift);
                        bus.overflow_out <= 1'b0;
                        bus.invalid_out  <= 1'b0;
                        bus.inexact_out  <= sticky_next;
                    end
                end

                DONE: begin
                    if (bus.ready_in) begin
                        bus.valid_out <= 1'b0;
                        bus.ready_out <= 1'b1;
                        state         <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_float_to_int_converter.sv
// Self-checking bench for float_to_int_converter: directed corner values,
// handshake/reset scenarios and randomized operands checked against an
// arithmetic reference (integer division for truncation, range test for
// saturation). Latency is counted in rising edges from the accepting edge
// through the edge that raises valid_out, both inclusive.
module tb_float_to_int_converter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;

    float_to_int_converter_if #(.DATA_WIDTH(32)) bus ();

    float_to_int_converter #(
        .DATA_WIDTH(32), .MENT_WIDTH(23), .EXPO_WIDTH(8), .EXPO_BIAS(127)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        compared++;
        assert (obs === want) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    // Reference: value = sig * 2^(e-23), truncated toward zero, then
    // range-checked against the int32 range.
    task automatic model(input logic [31:0] f, output logic [31:0] r,
                         output logic ov, output logic iv, output logic ix,
                         output int n);
        logic   s;
        int     ex, e;
        longint full, mag, v, div;
        s = f[31]; ex = int'(f[30:23]);
        full = (longint'(1) << 23) + longint'(f[22:0]);
        r = 32'h0; ov = 1'b0; iv = 1'b0; ix = 1'b0; n = 0;
        if (ex == 255) begin
            if (f[22:0] != 0) begin r = 32'h8000_0000; iv = 1'b1; end
            else begin r = s ? 32'h8000_0000 : 32'h7FFF_FFFF; ov = 1'b1; end
        end else if (ex == 0) begin
            ix = (f[22:0] != 0);
        end else begin
            e = ex - 127;
            if (e < 0) begin
                ix = 1'b1;
            end else if (e > 40) begin
                r = s ? 32'h8000_0000 : 32'h7FFF_FFFF; ov = 1'b1;
            end else begin
                if (e >= 23) mag = full * (longint'(1) << (e - 23));
                else begin
                    div = longint'(1) << (23 - e);
                    mag = full / div;
                    ix  = (full % div) != 0;
                end
                v = s ? -mag : mag;
                if (v > 64'sd2147483647 || v < -64'sd2147483648) begin
                    r = s ? 32'h8000_0000 : 32'h7FFF_FFFF; ov = 1'b1; ix = 1'b0;
                end else begin
                    r = v[31:0];
                    if (e <= 30) n = (e >= 23) ? e - 23 : 23 - e;
                end
            end
        end
    endtask

    // Present f until accepted; returns at the negedge after the accept edge
    task automatic start(input logic [31:0] f);
        int guard = 0;
        while (!bus.ready_out && guard < 100) begin @(negedge clk); guard++; end
        bus.floating_in = f;
        bus.valid_in    = 1'b1;
        @(negedge clk);
        bus.valid_in    = 1'b0;
    endtask

    task automatic wait_valid(output int edges);
        edges = 1;
        while (!bus.valid_out && edges < 64) begin @(negedge clk); edges++; end
    endtask

    task automatic run_conv(input logic [31:0] f, input string tag);
        logic [31:0] r;
        logic ov, iv, ix;
        int n, edges;
        model(f, r, ov, iv, ix, n);
        start(f);
        wait_valid(edges);
        check({tag, ".valid"}, 32'(bus.valid_out), 32'd1);
        check({tag, ".int"},   bus.integer_out, r);
        check({tag, ".ovf"},   32'(bus.overflow_out), 32'(ov));
        check({tag, ".inv"},   32'(bus.invalid_out), 32'(iv));
        check({tag, ".inx"},   32'(bus.inexact_out), 32'(ix));
        check({tag, ".lat"},   32'(edges), 32'(n + 2));
        @(negedge clk);
        check({tag, ".idle_rdy"}, 32'(bus.ready_out), 32'd1);
        check({tag, ".idle_vld"}, 32'(bus.valid_out), 32'd0);
    endtask

    logic [31:0] directed [16] = '{
        32'h3F80_0000, 32'hC020_0000, 32'h4E80_0000, 32'h4B00_0000,
        32'hCF00_0000, 32'h4F00_0000, 32'hFF80_0000, 32'h7FC0_0000,
        32'h3F00_0000, 32'h0000_0001, 32'h7F80_0000, 32'hCF00_0001,
        32'h8000_0000, 32'h4EFF_FFFF, 32'hC0FF_FFFF, 32'h4B7F_FFFF
    };

    initial begin
        logic [31:0] r, f;
        logic ov, iv, ix;
        int n, edges;
        logic [7:0] ex;
        logic [22:0] mt;

        bus.valid_in    = 1'b0;
        bus.floating_in = '0;
        bus.ready_in    = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.rdy", 32'(bus.ready_out), 32'd1);
        check("rst.vld", 32'(bus.valid_out), 32'd0);
        check("rst.int", bus.integer_out, 32'd0);
        check("rst.flags", {29'd0, bus.overflow_out, bus.invalid_out, bus.inexact_out}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed values, including the saturation and sub-unity boundaries
        foreach (directed[i]) run_conv(directed[i], $sformatf("dir%0d", i));

        // Downstream stall: result and flags hold, new valid_in pulses ignored
        bus.ready_in = 1'b0;
        model(32'h3FC0_0000, r, ov, iv, ix, n);
        start(32'h3FC0_0000);
        wait_valid(edges);
        check("stall.lat", 32'(edges), 32'(n + 2));
        for (int i = 0; i < 5; i++) begin
            bus.valid_in    = i[0];
            bus.floating_in = $urandom;
            @(negedge clk);
            check($sformatf("stall%0d.int", i), bus.integer_out, r);
            check($sformatf("stall%0d.inx", i), 32'(bus.inexact_out), 32'(ix));
            check($sformatf("stall%0d.vld", i), 32'(bus.valid_out), 32'd1);
            check($sformatf("stall%0d.rdy", i), 32'(bus.ready_out), 32'd0);
        end
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b1;
        @(negedge clk);
        check("release.rdy", 32'(bus.ready_out), 32'd1);
        check("release.vld", 32'(bus.valid_out), 32'd0);
        @(negedge clk);
        check("release.still_idle", 32'(bus.ready_out), 32'd1);

        // Reset during SHIFT aborts the conversion
        start(32'h3F80_0000);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort.rdy", 32'(bus.ready_out), 32'd1);
        check("abort.vld", 32'(bus.valid_out), 32'd0);
        check("abort.int", bus.integer_out, 32'd0);
        check("abort.flags", {29'd0, bus.overflow_out, bus.invalid_out, bus.inexact_out}, 32'd0);
        repeat (30) @(negedge clk);
        check("abort.no_result", 32'(bus.valid_out), 32'd0);
        run_conv(32'hC020_0000, "post_abort");

        // Randomized operands, biased toward the interesting exponent band
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0:       ex = 8'd0;
                1:       ex = 8'hFF;
                default: ex = 8'($urandom_range(100, 160));
            endcase
            mt = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
            f  = {1'($urandom), ex, mt};
            run_conv(f, $sformatf("rnd%0d_%h", i, f));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
